// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: bypass select values
// and the multiply sequencer states.
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mul_state_t;

endpackage

// File: rtl/fwd_sel.sv
// One bypass select: the Memory stage wins over Writeback, and the register
// file is used when neither later stage supplies the operand.
module fwd_sel
  import hazard_pkg::*;
(
  input  logic       match_m,
  input  logic       match_w,
  input  logic       en_m,
  input  logic       en_w,
  output logic [1:0] sel
);

  always_comb begin
    sel = FWD_RF;
    if (match_m && en_m)      sel = FWD_M;
    else if (match_w && en_w) sel = FWD_W;
  end

endmodule

// File: rtl/hazard_controller.sv
// Hazard and sequencing controller for the five-stage ARM pipeline: bypass
// selects, load-use and multiply stalls, PC-write tracking and flushes.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int unsigned MUL_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Match_1E_M,
  input  logic       Match_1E_W,
  input  logic       Match_2E_M,
  input  logic       Match_2E_W,
  input  logic       Match_3E_M,
  input  logic       Match_3E_W,
  input  logic       Match_1E_M_Index,
  input  logic       Match_1E_W_Index,
  input  logic       Match_2E_M_Index,
  input  logic       Match_2E_W_Index,
  input  logic       Match_3E_M_Index,
  input  logic       Match_3E_W_Index,
  input  logic       Match_12D_E,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       WriteBackM,
  input  logic       WriteBackW,
  input  logic       MemtoRegE,
  input  logic       PCSrcD,
  input  logic       CondExE,
  input  logic       BranchTakenD,
  input  logic       MulOpE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic [1:0] ForwardCE,
  output logic [1:0] ForwardAEIndex,
  output logic [1:0] ForwardBEIndex,
  output logic [1:0] ForwardCEIndex,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushM,
  output logic       PCSrcW
);

  localparam logic       MUL_MULTI = (MUL_LAT > 1);
  localparam logic [3:0] MUL_LAST  = 4'(MUL_LAT - 1);

  fwd_sel u_fwd_a  (.match_m(Match_1E_M),       .match_w(Match_1E_W),       .en_m(RegWriteM),  .en_w(RegWriteW),  .sel(ForwardAE));
  fwd_sel u_fwd_b  (.match_m(Match_2E_M),       .match_w(Match_2E_W),       .en_m(RegWriteM),  .en_w(RegWriteW),  .sel(ForwardBE));
  fwd_sel u_fwd_c  (.match_m(Match_3E_M),       .match_w(Match_3E_W),       .en_m(RegWriteM),  .en_w(RegWriteW),  .sel(ForwardCE));
  fwd_sel u_fwd_ai (.match_m(Match_1E_M_Index), .match_w(Match_1E_W_Index), .en_m(WriteBackM), .en_w(WriteBackW), .sel(ForwardAEIndex));
  fwd_sel u_fwd_bi (.match_m(Match_2E_M_Index), .match_w(Match_2E_W_Index), .en_m(WriteBackM), .en_w(WriteBackW), .sel(ForwardBEIndex));
  fwd_sel u_fwd_ci (.match_m(Match_3E_M_Index), .match_w(Match_3E_W_Index), .en_m(WriteBackM), .en_w(WriteBackW), .sel(ForwardCEIndex));

  mul_state_t state;
  logic [3:0] cnt;
  logic       pc_e, pc_m, pc_w;
  logic       ld_stall, mul_stall, pc_pending;

  always_comb begin
    ld_stall   = Match_12D_E & MemtoRegE;
    mul_stall  = ((state == IDLE) & MulOpE & MUL_MULTI) |
                 ((state == BUSY) & (cnt != MUL_LAST));
    pc_pending = PCSrcD | pc_e | pc_m;

    StallF = ld_stall | pc_pending | mul_stall;
    StallD = ld_stall | mul_stall;
    StallE = mul_stall;
    // A PC write reaching Writeback must always kill Decode, even while stalled.
    FlushD = (pc_pending | pc_w | BranchTakenD) & (~StallD | pc_w);
    FlushE = ld_stall & ~mul_stall;
    FlushM = mul_stall;
    PCSrcW = pc_w;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      pc_e  <= 1'b0;
      pc_m  <= 1'b0;
      pc_w  <= 1'b0;
    end else begin
      pc_e <= FlushE ? 1'b0 : (StallE ? pc_e : PCSrcD);
      pc_m <= FlushM ? 1'b0 : (pc_e & CondExE);
      pc_w <= pc_m;
      case (state)
        IDLE: begin
          if (MulOpE && MUL_MULTI) begin
            state <= BUSY;
            cnt   <= 4'd1;
          end
        end
        BUSY: begin
          if (cnt == MUL_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller (MUL_LAT=4): directed scenarios with literal
// expectations, then random stimulus against a behavioural model every cycle.
module tb_hazard_controller;

  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;
  logic m1m, m1w, m2m, m2w, m3m, m3w;
  logic i1m, i1w, i2m, i2w, i3m, i3w;
  logic m12, rwm, rww, wbm, wbw, memtoreg, pcsrcd, condex, bt, mulop;
  logic [1:0] fa, fb, fc, fai, fbi, fci;
  logic sf, sd, se, fd, fe, fm, pcw;

  int n_cmp = 0;
  int n_bad = 0;
  bit run_cmp = 0;

  always #5 clk = ~clk;

  hazard_controller #(.MUL_LAT(N)) dut (
    .clk(clk), .reset(reset),
    .Match_1E_M(m1m), .Match_1E_W(m1w), .Match_2E_M(m2m), .Match_2E_W(m2w),
    .Match_3E_M(m3m), .Match_3E_W(m3w),
    .Match_1E_M_Index(i1m), .Match_1E_W_Index(i1w), .Match_2E_M_Index(i2m),
    .Match_2E_W_Index(i2w), .Match_3E_M_Index(i3m), .Match_3E_W_Index(i3w),
    .Match_12D_E(m12), .RegWriteM(rwm), .RegWriteW(rww),
    .WriteBackM(wbm), .WriteBackW(wbw), .MemtoRegE(memtoreg),
    .PCSrcD(pcsrcd), .CondExE(condex), .BranchTakenD(bt), .MulOpE(mulop),
    .ForwardAE(fa), .ForwardBE(fb), .ForwardCE(fc),
    .ForwardAEIndex(fai), .ForwardBEIndex(fbi), .ForwardCEIndex(fci),
    .StallF(sf), .StallD(sd), .StallE(se),
    .FlushD(fd), .FlushE(fe), .FlushM(fm), .PCSrcW(pcw)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // busy_left: cycles still to be spent in the multiply after the trigger
  // cycle; pipe[0..2] = "instruction in E/M/W will write the PC".
  int busy_left = 0;
  bit pipe[3] = '{0, 0, 0};

  function automatic logic [1:0] fwd(input logic m, input logic w, input logic em, input logic ew);
    if (m && em) return 2'd2;
    if (w && ew) return 2'd1;
    return 2'd0;
  endfunction

  // Packed order: fa fb fc fai fbi fci sf sd se fd fe fm pcw
  function automatic logic [18:0] model_out();
    logic ld, mul, pend, sD, fD;
    ld   = m12 & memtoreg;
    mul  = (busy_left > 0) ? (busy_left > 1) : (mulop && N > 1);
    pend = pcsrcd | pipe[0] | pipe[1];
    sD   = ld | mul;
    if (pipe[2])  fD = 1'b1;
    else if (sD)  fD = 1'b0;
    else          fD = pend | bt;
    return {fwd(m1m, m1w, rwm, rww), fwd(m2m, m2w, rwm, rww), fwd(m3m, m3w, rwm, rww),
            fwd(i1m, i1w, wbm, wbw), fwd(i2m, i2w, wbm, wbw), fwd(i3m, i3w, wbm, wbw),
            ld | pend | mul, sD, mul, fD, ld & ~mul, mul, logic'(pipe[2])};
  endfunction

  always @(posedge clk) begin
    logic [18:0] o;
    o = model_out();
    if (reset) begin
      busy_left = 0;
      pipe = '{0, 0, 0};
    end else begin
      pipe[2] = pipe[1];
      pipe[1] = o[1] ? 1'b0 : (pipe[0] & condex);
      pipe[0] = o[2] ? 1'b0 : (o[4] ? pipe[0] : pcsrcd);
      if (busy_left > 0)             busy_left--;
      else if (mulop && N > 1)       busy_left = N - 1;
    end
  end

  function automatic logic [18:0] dut_out();
    return {fa, fb, fc, fai, fbi, fci, sf, sd, se, fd, fe, fm, pcw};
  endfunction

  always @(negedge clk) if (run_cmp) chk("model_vs_dut", 32'(dut_out()), 32'(model_out()));

  // ---------------- stimulus ----------------
  task automatic clear_in();
    {m1m, m1w, m2m, m2w, m3m, m3w, i1m, i1w, i2m, i2w, i3m, i3w} = '0;
    {m12, rwm, rww, wbm, wbw, memtoreg, pcsrcd, condex, bt, mulop} = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_in();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    run_cmp = 1;
    #1 chk("reset_all_zero", 32'(dut_out()), 32'd0);

    // forwarding priority
    step();
    m1m = 1; rwm = 1; m1w = 1; rww = 1;
    #1 chk("fwdA_mem", 32'(fa), 32'd2);
    rwm = 0;
    #1 chk("fwdA_wb", 32'(fa), 32'd1);
    i1m = 1; wbm = 1; i1w = 1; wbw = 1;
    #1 chk("fwdAidx_mem", 32'(fai), 32'd2);
    wbm = 0;
    #1 chk("fwdAidx_wb", 32'(fai), 32'd1);
    m3w = 1;
    #1 chk("fwdC_wb", 32'(fc), 32'd1);
    chk("fwdB_rf", 32'(fb), 32'd0);

    // load-use
    step(); clear_in();
    m12 = 1; memtoreg = 1;
    #1 chk("ld_stalls", 32'({sf, sd, fe, se}), 32'b1110);
    step(); clear_in();
    #1 chk("ld_released", 32'({sf, sd, fe, se}), 32'b0000);

    // multiply MUL_LAT=4: stall t..t+2, release t+3, IDLE at t+4
    step(); mulop = 1;
    #1 chk("mul_t0", 32'({sf, sd, se, fm}), 32'b1111);
    step(); mulop = 0;
    #1 chk("mul_t1", 32'({sf, sd, se, fm}), 32'b1111);
    step();
    #1 chk("mul_t2", 32'({sf, sd, se, fm}), 32'b1111);
    step();
    #1 chk("mul_release", 32'({sf, sd, se, fm}), 32'b0000);
    step(); mulop = 1;
    #1 chk("mul_idle_retrigger", 32'(se), 32'd1);
    step(); mulop = 0; reset = 1;
    #1 chk("mul_stall_during_reset", 32'(se), 32'd1);
    step(); reset = 0;
    #1 chk("mul_reset_idle", 32'(dut_out()), 32'd0);
    step();
    #1 chk("mul_reset_stays_idle", 32'(dut_out()), 32'd0);

    // PC write with condition passing
    step(); pcsrcd = 1;
    #1 chk("pc_d", 32'({sf, fd, pcw}), 32'b110);
    step(); pcsrcd = 0; condex = 1;
    #1 chk("pc_e", 32'({sf, fd, pcw}), 32'b110);
    step(); condex = 0;
    #1 chk("pc_m", 32'({sf, fd, pcw}), 32'b110);
    step();
    #1 chk("pc_w", 32'({sf, fd, pcw}), 32'b011);
    step();
    #1 chk("pc_done", 32'({sf, fd, pcw}), 32'b000);

    // PC write with condition failing
    step(); pcsrcd = 1;
    step(); pcsrcd = 0; condex = 0;
    step();
    step();
    #1 chk("pc_condfail_no_w", 32'({fd, pcw}), 32'b00);

    // taken branch alone
    step(); bt = 1;
    #1 chk("branch_flushD", 32'({fd, sf, sd, se, fe, fm}), 32'b100000);
    step(); clear_in();

    // random phase
    for (int c = 0; c < 3000; c++) begin
      step();
      {m1m, m1w, m2m, m2w, m3m, m3w} = 6'($urandom);
      {i1m, i1w, i2m, i2w, i3m, i3w} = 6'($urandom);
      {rwm, rww, wbm, wbw, condex} = 5'($urandom);
      m12      = ($urandom_range(0, 3) == 0);
      memtoreg = ($urandom_range(0, 2) == 0);
      pcsrcd   = ($urandom_range(0, 9) == 0);
      bt       = ($urandom_range(0, 9) == 0);
      mulop    = ($urandom_range(0, 7) == 0);
      reset    = ($urandom_range(0, 49) == 0);
    end
    step(); clear_in(); reset = 0;
    step(); step();
    run_cmp = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline hazard and sequencing controller for the five-stage ARM datapath.
- Generates all forwarding selects (primary result path and base-register writeback path), stall, flush and bubble controls.
- Owns the PC-write tracking state from Decode through Writeback and the multi-cycle multiply sequencer that freezes the front end while Execute holds a multiply.
- Sits beside the controller; consumes the datapath's register-match flags and the per-stage control bits.

## Interface
Parameters:
- MUL_LAT, default 1: Execute-stage cycles per multiply (1 = single-cycle, no stall); legal range 1..15.

Ports:
- clk  in  1  clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_3E_M, Match_3E_W  in  1 each  Execute source operand 1/2/3 equals Memory/Writeback destination.
- Match_1E_M_Index … Match_3E_W_Index  in  1 each  Execute source equals Memory/Writeback base-writeback register.
- Match_12D_E  in  1  Decode source equals Execute destination.
- RegWriteM, RegWriteW  in  1  destination write enable in Memory/Writeback.
- WriteBackM, WriteBackW  in  1  base-register writeback enable in Memory/Writeback.
- MemtoRegE  in  1  Execute instruction is a load.
- PCSrcD  in  1  Decode instruction writes R15 (unconditional intent).
- CondExE  in  1  Execute instruction's condition passed.
- BranchTakenD  in  1  branch resolved taken in Decode.
- MulOpE  in  1  Execute instruction is a multiply.
- ForwardAE, ForwardBE, ForwardCE  out  2  result-path bypass selects.
- ForwardAEIndex, ForwardBEIndex, ForwardCEIndex  out  2  writeback-path bypass selects.
- StallF, StallD, StallE  out  1  hold PC, Decode register, Execute registers.
- FlushD, FlushE, FlushM  out  1  insert bubble into Decode, Execute, Memory.
- PCSrcW  out  1  Writeback instruction writes PC (drives the PC mux).

## Operation
- Forward select for operand x:
  - 2'b10 if Match_xE_M & RegWriteM;
  - else 2'b01 if Match_xE_W & RegWriteW;
  - else 2'b00.
  - Memory has priority over Writeback.
- Index select for operand x uses the same rule with the _Index matches and WriteBackM/W.
- LdStall = Match_12D_E & MemtoRegE.
- PC tracking registers pcE, pcM, pcW:
  - pcE <= FlushE ? 0 : (StallE ? pcE : PCSrcD);
  - pcM <= FlushM ? 0 : pcE & CondExE;
  - pcW <= pcM.
  - PCSrcW = pcW.
  - PCPending = PCSrcD | pcE | pcM.
- Multiply sequencer, states IDLE / BUSY, counter cnt of 4 bits:
  - IDLE -> BUSY when MulOpE & MUL_LAT>1; cnt loads 1.
  - In BUSY, cnt increments each cycle; BUSY -> IDLE when cnt == MUL_LAT-1.
  - MulStall = (IDLE & MulOpE & MUL_LAT>1) | (BUSY & cnt != MUL_LAT-1).
- Outputs:
  - StallF = LdStall | PCPending | MulStall.
  - StallD = LdStall | MulStall.
  - StallE = MulStall.
  - FlushD = PCPending | PCSrcW | BranchTakenD.
  - FlushD is suppressed while StallD = 1, except when PCSrcW = 1.
  - FlushE = LdStall & ~MulStall.
  - FlushM = MulStall.

## Timing
- Forward and stall/flush outputs are combinational from inputs and current state, with no added latency.
- Reset: pcE, pcM, pcW = 0; state IDLE; cnt = 0. With all inputs 0, every output is 0.
- Multiply, MUL_LAT = N:
  - MulOpE seen in cycle t gives MulStall = 1 in cycles t..t+N-2.
  - Released in t+N-1.
  - The multiply reaches Memory at t+N.
  - Exactly one Memory-stage instance is produced, because FlushM bubbles the stalled cycles.
- Load-use: one-cycle stall of F/D and a bubble into E. Load-use coincident with MulStall defers to MulStall; the load-use is re-evaluated after release.
- A PC write holds F stalled and D flushed for 3 cycles (D, E, M).
  - A failed condition in E clears pcM, so PCSrcW is never asserted for it.
  - PCSrcW forces FlushD for one cycle.
- Reset asserted mid-multiply returns the block to IDLE on the next edge.

## Structure
- Package hazard_pkg: FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10; state encoding IDLE/BUSY.
- Sub-module fwd_sel (match_m, match_w, en_m, en_w -> sel[1:0]), instantiated six times.
- The multiply FSM and PC tracking stay inline.

## Test plan
- Match_1E_M=1, RegWriteM=1, Match_1E_W=1, RegWriteW=1 -> ForwardAE=2'b10. Drop RegWriteM -> ForwardAE=2'b01. Index path likewise with WriteBackM/W.
- Match_12D_E=1, MemtoRegE=1 for one cycle -> StallF=StallD=FlushE=1 that cycle only, and StallE=0.
- MUL_LAT=4, MulOpE pulse at cycle 10 -> StallF/D/E=FlushM=1 in cycles 10-12, 0 at cycle 13, state IDLE at 14.
- PCSrcD=1, then CondExE=1 -> PCSrcW=1 three cycles later; FlushD=1 over four consecutive cycles. Repeat with CondExE=0 -> PCSrcW stays 0.
- BranchTakenD=1 alone -> FlushD=1 only, with no stalls.
- Reset at cycle 11 of the multiply in scenario 3 -> all outputs 0 and state IDLE at cycle 12.
